// File: rtl/rstn_gen_if.sv
// Handshake bundle between the reset generator, its requester and the
// destination reset domain it controls.
interface rstn_gen_if;
  logic i_soft_rst_req;
  logic i_dst_rst_n;
  logic o_rst_n;
  logic o_busy;
  logic o_done;
  logic o_err;

  modport master (
    output i_soft_rst_req,
    output i_dst_rst_n,
    input  o_rst_n,
    input  o_busy,
    input  o_done,
    input  o_err
  );

  modport slave (
    input  i_soft_rst_req,
    input  i_dst_rst_n,
    output o_rst_n,
    output o_busy,
    output o_done,
    output o_err
  );
endinterface

// File: rtl/rstn_gen.sv
// Reset-generation side of the async-assert / sync-release scheme: drives a
// registered active-low reset into a destination domain and handshakes on its ack.
module rstn_gen #(
  parameter int unsigned RST_HOLD_CYC = 16,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter int unsigned ACK_SYNC_LVL = 2
) (
  input  logic      i_clk,
  input  logic      i_asyn_rst_n,
  rstn_gen_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACK_SYNC_LVL-1:0] ack_sync_q;
  logic                    rst_n_q, rst_n_d;
  logic                    err_q, err_d;
  logic                    dst_ack_s;
  logic                    cnt_run_s;

  assign dst_ack_s = ack_sync_q[ACK_SYNC_LVL-1];

  // Bring the destination's reset level into this clock domain.
  always_ff @(posedge i_clk or negedge i_asyn_rst_n) begin
    if (!i_asyn_rst_n) begin
      ack_sync_q <= {ACK_SYNC_LVL{1'b0}};
    end else begin
      ack_sync_q <= {ack_sync_q[ACK_SYNC_LVL-2:0], bus.i_dst_rst_n};
    end
  end

  // Sequence FSM: next state, sticky error and the hold/timeout counter.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cnt_run_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_soft_rst_req) begin
          state_d = ST_ASSERT;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        cnt_run_s = 1'b1;
        if ((cnt_q >= HOLD_LAST) && !dst_ack_s) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      ST_RELEASE: begin
        cnt_run_s = 1'b1;
        if (dst_ack_s) begin
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every transition is a state entry, so the counter restarts on any change.
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_run_s && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    rst_n_d = (state_d != ST_ASSERT);
  end

  // State, counter, error and the generated reset flop.
  always_ff @(posedge i_clk or negedge i_asyn_rst_n) begin
    if (!i_asyn_rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= CNT_ZERO;
      err_q   <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign bus.o_rst_n = rst_n_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_done  = (state_q == ST_DONE);
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_rstn_gen.sv
// Randomized bench for rstn_gen: a behavioural destination domain plus a
// closed-form model of reset low time, release latency and error outcome.
module tb_rstn_gen;

  localparam int HOLD = 16;
  localparam int TO   = 64;
  localparam int LVL  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   dst_mode;
  int   d_fall;
  int   d_rise;
  logic prev_err;

  rstn_gen_if bus_if ();

  rstn_gen #(
    .RST_HOLD_CYC(HOLD),
    .TIMEOUT_CYC (TO),
    .ACK_SYNC_LVL(LVL)
  ) dut (
    .i_clk       (clk),
    .i_asyn_rst_n(rst_n),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: destination drops its reset d_fall cycles after our reset falls; the
  // ack is seen LVL cycles later; exit no earlier than HOLD, no later than TO.
  function automatic int exp_low(input int d);
    int l;
    l = (d + LVL + 1 > HOLD) ? d + LVL + 1 : HOLD;
    return (l > TO) ? TO : l;
  endfunction

  // Model: cycles from reset rising to the o_done cycle.
  function automatic int exp_delta(input int r);
    int j;
    j = (r + LVL < TO - 1) ? r + LVL : TO - 1;
    return j + 1;
  endfunction

  function automatic logic exp_rel_err(input int r);
    return (r + LVL > TO - 1);
  endfunction

  // Destination domain: mode 0 follows o_rst_n after delays, 1 stuck high, 2 stuck low.
  initial begin : dst_model
    int   run_cnt;
    logic prev_rst;
    run_cnt = 0;
    prev_rst = 1'b0;
    bus_if.i_dst_rst_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.o_rst_n !== prev_rst) run_cnt = 0;
      else if (run_cnt < 10000) run_cnt++;
      prev_rst = bus_if.o_rst_n;
      case (dst_mode)
        1:       bus_if.i_dst_rst_n = 1'b1;
        2:       bus_if.i_dst_rst_n = 1'b0;
        default: bus_if.i_dst_rst_n = bus_if.o_rst_n ? (run_cnt >= d_rise) : (run_cnt < d_fall);
      endcase
    end
  end

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
    check_eq("idle_busy", bus_if.o_busy, 0);
    check_eq("idle_rst_n", bus_if.o_rst_n, 1);
    check_eq("idle_err_sticky", bus_if.o_err, prev_err);
  endtask

  task automatic start_soft();
    bus_if.i_soft_rst_req = 1'b1;
    @(negedge clk);
    bus_if.i_soft_rst_req = 1'b0;
    check_eq("req_rst_n_low", bus_if.o_rst_n, 0);
    check_eq("req_err_clr", bus_if.o_err, 0);
    check_eq("req_busy", bus_if.o_busy, 1);
  endtask

  // Entered at the negedge of ASSERT cycle 0 (soft) or cycle 1 (power-on).
  task automatic measure(input string nm, input int exp_l, input int exp_d,
                         input logic exp_err, input bit po, input bit inject);
    int l_obs;
    int k;
    int stray;
    l_obs = po ? 1 : 0;
    stray = 0;
    while (bus_if.o_rst_n === 1'b0 && l_obs < 300) begin
      bus_if.i_soft_rst_req = (inject && l_obs == 3);
      if (bus_if.o_done === 1'b1) stray++;
      l_obs++;
      @(negedge clk);
    end
    bus_if.i_soft_rst_req = 1'b0;
    check_eq({nm, "_low_cycles"}, l_obs, exp_l);
    check_eq({nm, "_no_early_done"}, stray, 0);
    k = 0;
    while (bus_if.o_done !== 1'b1 && k < 300) begin
      bus_if.i_soft_rst_req = (inject && k == 0);
      k++;
      @(negedge clk);
    end
    bus_if.i_soft_rst_req = 1'b0;
    check_eq({nm, "_release_to_done"}, k, exp_d);
    check_eq({nm, "_err"}, bus_if.o_err, exp_err);
    check_eq({nm, "_busy_in_done"}, bus_if.o_busy, 1);
    bus_if.i_soft_rst_req = inject;
    @(negedge clk);
    bus_if.i_soft_rst_req = 1'b0;
    check_eq({nm, "_done_single"}, bus_if.o_done, 0);
    check_eq({nm, "_idle_busy"}, bus_if.o_busy, 0);
    @(negedge clk);
    check_eq({nm, "_not_queued_busy"}, bus_if.o_busy, 0);
    check_eq({nm, "_not_queued_rst"}, bus_if.o_rst_n, 1);
    check_eq({nm, "_err_held"}, bus_if.o_err, exp_err);
    prev_err = exp_err;
  endtask

  task automatic abort_and_restart(input string nm);
    #2;
    rst_n = 1'b0;
    dst_mode = 0;
    d_fall = 0;
    d_rise = $urandom_range(0, 70);
    #1;
    check_eq({nm, "_rst_n_now"}, bus_if.o_rst_n, 0);
    check_eq({nm, "_err_clr"}, bus_if.o_err, 0);
    check_eq({nm, "_busy"}, bus_if.o_busy, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq({nm, "_hold_rst_n"}, bus_if.o_rst_n, 0);
      check_eq({nm, "_hold_done"}, bus_if.o_done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    measure({nm, "_por"}, HOLD, exp_delta(d_rise), exp_rel_err(d_rise), 1'b1, 1'b0);
  endtask

  initial begin
    int sel;
    int d;
    int r;
    int n;
    bit inj;
    checks = 0;
    failures = 0;
    prev_err = 1'b0;
    rst_n = 1'b1;
    bus_if.i_soft_rst_req = 1'b0;
    dst_mode = 0;
    d_fall = 0;
    d_rise = $urandom_range(0, 20);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("por_rst_n", bus_if.o_rst_n, 0);
      check_eq("por_busy", bus_if.o_busy, 1);
      check_eq("por_done", bus_if.o_done, 0);
      check_eq("por_err", bus_if.o_err, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    measure("por", HOLD, exp_delta(d_rise), exp_rel_err(d_rise), 1'b1, 1'b0);

    for (int it = 0; it < 24; it++) begin
      sel = (it < 5) ? it : $urandom_range(0, 7);
      if (sel > 4) sel = 0;
      d = (it == 0) ? TO - LVL - 1 : $urandom_range(0, TO - LVL - 1);
      r = (it == 0) ? 0 : $urandom_range(0, 70);
      inj = $urandom_range(0, 1);
      case (sel)
        1: begin
          dst_mode = 1;
          idle_gap(80);
          start_soft();
          measure("dead_hi", TO, 1, 1'b1, 1'b0, inj);
        end
        2: begin
          dst_mode = 2;
          idle_gap(80);
          start_soft();
          measure("dead_lo", HOLD, TO, 1'b1, 1'b0, inj);
        end
        3: begin
          dst_mode = 0;
          d_fall = d;
          d_rise = r;
          idle_gap(80);
          start_soft();
          repeat ($urandom_range(1, 10)) @(negedge clk);
          abort_and_restart("abort_assert");
        end
        4: begin
          dst_mode = 1;
          idle_gap(80);
          start_soft();
          n = 0;
          while (bus_if.o_rst_n === 1'b0 && n < 300) begin
            n++;
            @(negedge clk);
          end
          check_eq("abort_rel_low_cycles", n, TO);
          check_eq("abort_rel_err_set", bus_if.o_err, 1);
          abort_and_restart("abort_release");
        end
        default: begin
          dst_mode = 0;
          d_fall = d;
          d_rise = r;
          idle_gap(80);
          start_soft();
          measure("soft", exp_low(d), exp_delta(r), exp_rel_err(r), 1'b0, inj);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
